id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operand forwarding at capture time and
// holds the selected ALU operands and write-back control for the EX stage.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [3:0]  alu_sel_in,
  input  logic        a_sel,
  input  logic        b_sel,
  input  logic        is_link,
  input  logic        reg_we_in,
  input  logic [4:0]  exm_rd,
  input  logic        exm_we,
  input  logic [31:0] exm_val,
  input  logic [4:0]  wb_rd,
  input  logic        wb_we,
  input  logic [31:0] wb_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic [4:0]  rd_out,
  output logic        reg_we_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RIDXW = 5;
  localparam int unsigned OPW   = 4;
  localparam logic [OPW-1:0] OP_PASS_A = 4'b1111;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] cap_a;
  logic [XLEN-1:0] cap_b;
  logic [OPW-1:0]  cap_sel;
  logic            cap_we;
  logic            load;

  // Accept when empty or when the held instruction leaves this cycle
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign pc_plus4 = pc + XLEN'(4);

  // rs1 bypass: x0 reads zero, EX/MEM beats MEM/WB, else register file
  always_comb begin
    fwd_rs1 = rs1_data;
    if (rs1_addr == RIDXW'(0)) begin
      fwd_rs1 = '0;
    end else if (exm_we && (exm_rd == rs1_addr)) begin
      fwd_rs1 = exm_val;
    end else if (wb_we && (wb_rd == rs1_addr)) begin
      fwd_rs1 = wb_val;
    end
  end

  // rs2 bypass: same priority as rs1
  always_comb begin
    fwd_rs2 = rs2_data;
    if (rs2_addr == RIDXW'(0)) begin
      fwd_rs2 = '0;
    end else if (exm_we && (exm_rd == rs2_addr)) begin
      fwd_rs2 = exm_val;
    end else if (wb_we && (wb_rd == rs2_addr)) begin
      fwd_rs2 = wb_val;
    end
  end

  // Operand/control selection for the instruction being captured
  always_comb begin
    cap_a   = fwd_rs1;
    cap_b   = fwd_rs2;
    cap_sel = alu_sel_in;
    cap_we  = reg_we_in && (rd_addr != RIDXW'(0));
    if (is_link) begin
      cap_a   = pc_plus4;
      cap_sel = OP_PASS_A;
    end else if (a_sel) begin
      cap_a = pc;
    end
    if (b_sel) begin
      cap_b = imm;
    end
  end

  // Pipeline register: reset > flush > load > drain; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rd_out     <= '0;
      reg_we_out <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      reg_we_out <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      alu_a      <= cap_a;
      alu_b      <= cap_b;
      alu_sel    <= cap_sel;
      rd_out     <= rd_addr;
      reg_we_out <= cap_we;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [3:0]  alu_sel_in;
  logic        a_sel, b_sel, is_link, reg_we_in;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_we, wb_we;
  logic [31:0] exm_val, wb_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [4:0]  rd_out;
  logic        reg_we_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_sel_in(alu_sel_in), .a_sel(a_sel), .b_sel(b_sel),
    .is_link(is_link), .reg_we_in(reg_we_in),
    .exm_rd(exm_rd), .exm_we(exm_we), .exm_val(exm_val),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_val(wb_val),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .rd_out(rd_out), .reg_we_out(reg_we_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; pc = '0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; alu_sel_in = '0;
    a_sel = 0; b_sel = 0; is_link = 0; reg_we_in = 0;
    exm_rd = '0; exm_we = 0; exm_val = '0; wb_rd = '0; wb_we = 0; wb_val = '0;
    flush = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1; in_valid = 1; rs1_addr = 5'd1; rs1_data = 32'hDEAD; rd_addr = 5'd3; reg_we_in = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++;
    if ({out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b a=%h b=%h sel=%h rd=%h we=%b exp all zero",
               out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out);
    end
    rst = 0;
    drive_idle();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    drive_idle();
    rs1_addr = 5'd1; rs1_data = 32'd5; rs2_addr = 5'd2; rs2_data = 32'd7;
    rd_addr = 5'd9; reg_we_in = 1; in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
    if ({out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out} !== {1'b1, 32'd5, 32'd7, 4'd0, 5'd9, 1'b1}) begin
      errors++;
      $display("FAIL basic got v=%b a=%h b=%h sel=%h rd=%h we=%b exp v=1 a=5 b=7 sel=0 rd=9 we=1",
               out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      errors++;
      $display("FAIL basic_drain got v=%b a=%h b=%h exp v=0 a=5 b=7", out_valid, alu_a, alu_b);
    end
  endtask

  task automatic test_forward();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h11; exp_a[1] = 32'h22; exp_a[2] = 32'h0;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; rs1_data = 32'h99; rs1_addr = (i == 2) ? 5'd0 : 5'd3;
      exm_rd = 5'd3; exm_val = 32'h11; exm_we = (i == 0);
      wb_rd = 5'd3; wb_val = 32'h22; wb_we = 1;
      rs2_addr = 5'd3; b_sel = 1; imm = 32'hABC0 + 32'(i);
      tick();
      checks++;
      if (alu_a !== exp_a[i] || alu_b !== 32'hABC0 + 32'(i) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL forward_%0d got a=%h b=%h v=%b exp a=%h b=%h v=1",
                 i, alu_a, alu_b, out_valid, exp_a[i], 32'hABC0 + 32'(i));
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_link();
    drive_idle();
    in_valid = 1; is_link = 1; pc = 32'hFFFF_FFFC; alu_sel_in = 4'b0000;
    a_sel = 0; rs1_addr = 5'd4; rs1_data = 32'h1234; rd_addr = 5'd0; reg_we_in = 1;
    tick();
    in_valid = 0;
    checks++;
    if (alu_a !== 32'h0 || alu_sel !== 4'hF || reg_we_out !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL link got a=%h sel=%h we=%b v=%b exp a=0 sel=f we=0 v=1",
               alu_a, alu_sel, reg_we_out, out_valid);
    end
    tick();
  endtask

  task automatic test_stall();
    drive_idle();
    in_valid = 1; rs1_addr = 5'd4; exm_rd = 5'd4; exm_we = 1; exm_val = 32'h100;
    rs2_addr = 5'd5; rs2_data = 32'h55; alu_sel_in = 4'd2; rd_addr = 5'd6; reg_we_in = 1;
    tick();
    out_ready = 0;
    rs1_addr = 5'd7; rs1_data = 32'h77; rs2_addr = 5'd8; rs2_data = 32'h88;
    rd_addr = 5'd10; alu_sel_in = 4'd3;
    for (int i = 0; i < 3; i++) begin
      exm_val = 32'h200 + 32'(i);
      exm_rd = (i == 1) ? 5'd7 : 5'd4;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d got=%b exp=0", i, in_ready); end
      tick();
      checks++;
      if ({out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out} !== {1'b1, 32'h100, 32'h55, 4'd2, 5'd6, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b a=%h b=%h sel=%h rd=%h we=%b exp v=1 a=100 b=55 sel=2 rd=6 we=1",
                 i, out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out);
      end
    end
    out_ready = 1; exm_rd = 5'd4;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if ({out_valid, alu_a, alu_b, alu_sel, rd_out} !== {1'b1, 32'h77, 32'h88, 4'd3, 5'd10}) begin
      errors++;
      $display("FAIL stall_next got v=%b a=%h b=%h sel=%h rd=%h exp v=1 a=77 b=88 sel=3 rd=a",
               out_valid, alu_a, alu_b, alu_sel, rd_out);
    end
    tick();
  endtask

  task automatic test_flush();
    drive_idle();
    in_valid = 1; rs1_addr = 5'd2; rs1_data = 32'h5; rd_addr = 5'd2; reg_we_in = 1;
    tick();
    flush = 1; out_ready = 0; rd_addr = 5'd3; rs1_data = 32'h6;
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    checks++;
    if (out_valid !== 1'b0 || reg_we_out !== 1'b0) begin
      errors++;
      $display("FAIL flush got v=%b we=%b exp v=0 we=0", out_valid, reg_we_out);
    end
    tick();
  endtask

  task automatic test_reset_stall();
    drive_idle();
    in_valid = 1; rs1_addr = 5'd1; rs1_data = 32'hAA; rs2_addr = 5'd2; rs2_data = 32'hBB;
    alu_sel_in = 4'd5; rd_addr = 5'd7; reg_we_in = 1;
    tick();
    out_ready = 0; rst = 1;
    tick();
    rst = 0; in_valid = 0; out_ready = 1;
    checks++;
    if ({out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out} !== 75'd0) begin
      errors++;
      $display("FAIL reset_stall got v=%b a=%h b=%h sel=%h rd=%h we=%b exp all zero",
               out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out);
    end
  endtask

  // Reference: operand value an instruction sees for register r
  function automatic logic [31:0] ref_rs(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'd0;
    if (exm_we && exm_rd == r) return exm_val;
    if (wb_we && wb_rd == r) return wb_val;
    return rf;
  endfunction

  task automatic test_random();
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_sel;
    logic [4:0]  m_rd;
    logic        m_we;
    logic        accept;
    m_valid = 0; m_a = 0; m_b = 0; m_sel = 0; m_rd = 0; m_we = 0;
    drive_idle();
    rst = 1;
    tick();
    rst = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst        = ($urandom_range(0, 39) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      pc         = (cyc % 17 == 0) ? 32'hFFFF_FFFC : $urandom;
      rs1_addr   = 5'($urandom_range(0, 3));
      rs2_addr   = 5'($urandom_range(0, 3));
      rd_addr    = 5'($urandom_range(0, 3));
      rs1_data   = $urandom;
      rs2_data   = $urandom;
      imm        = $urandom;
      alu_sel_in = 4'($urandom_range(0, 15));
      a_sel      = 1'($urandom_range(0, 1));
      b_sel      = 1'($urandom_range(0, 1));
      is_link    = ($urandom_range(0, 5) == 0);
      reg_we_in  = 1'($urandom_range(0, 1));
      exm_rd     = 5'($urandom_range(0, 3));
      exm_we     = 1'($urandom_range(0, 1));
      exm_val    = $urandom;
      wb_rd      = 5'($urandom_range(0, 3));
      wb_we      = 1'($urandom_range(0, 1));
      wb_val     = $urandom;
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !m_valid || out_ready);
      end
      accept = in_valid && (!m_valid || out_ready);
      if (rst) begin
        m_valid = 0; m_a = 0; m_b = 0; m_sel = 0; m_rd = 0; m_we = 0;
      end else if (flush) begin
        m_valid = 0; m_we = 0;
      end else if (accept) begin
        m_valid = 1;
        m_a     = is_link ? pc + 32'd4 : (a_sel ? pc : ref_rs(rs1_addr, rs1_data));
        m_b     = b_sel ? imm : ref_rs(rs2_addr, rs2_data);
        m_sel   = is_link ? 4'hF : alu_sel_in;
        m_rd    = rd_addr;
        m_we    = reg_we_in && rd_addr != 0;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      tick();
      checks++;
      if ({out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out} !== {m_valid, m_a, m_b, m_sel, m_rd, m_we}) begin
        errors++;
        $display("FAIL rand_out cyc=%0d got v=%b a=%h b=%h sel=%h rd=%h we=%b exp v=%b a=%h b=%h sel=%h rd=%h we=%b",
                 cyc, out_valid, alu_a, alu_b, alu_sel, rd_out, reg_we_out,
                 m_valid, m_a, m_b, m_sel, m_rd, m_we);
      end
    end
    rst = 0;
    drive_idle();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_basic();
    test_forward();
    test_link();
    test_stall();
    test_flush();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
